// File: rtl/mc_controller.sv
// -----------------------------------------------------------------------------
// mc_controller
//   Multicycle control unit. A Moore FSM sequences each instruction through
//   fetch, decode, execute/memory and writeback. An ALU decoder and an
//   instruction decoder supply the remaining datapath controls. Memory-access
//   states (FETCH, MEMRD, MEMWR) can be stretched by MEM_WAIT fixed wait cycles.
//
// Parameters
//   MEM_WAIT    extra cycles held in FETCH/MEMRD/MEMWR (0..15)
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   Op          Instr[27:26]
//   Funct       Instr[25:20]
//   Rd          Instr[15:12]
//   FlagW       [1]=NZ write, [0]=CV write (to condlogic)
//   PCS         PC-write request: branch, or register writeback to R15
//   RegW        register write request (to condlogic)
//   MemW        memory write request (to condlogic)
//   Branch      branch indication (to condlogic)
//   NextPC      unconditional PC+4 write
//   IRWrite     instruction register load
//   AdrSrc      0=PC, 1=ALU result as memory address
//   ResultSrc   00=ALUOut, 01=Data, 10=ALUResult
//   ALUSrcA     0=RD1, 1=PC
//   ALUSrcB     00=RD2, 01=ExtImm, 10=constant 4
//   ALUControl  00 ADD, 01 SUB, 10 AND, 11 ORR
//   ImmSrc      equals Op
//   RegSrc      [0]=(Op==10), [1]=(Op==01)
// -----------------------------------------------------------------------------
module mc_controller #(
   parameter int unsigned MEM_WAIT = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   output logic [1:0] FlagW,
   output logic       PCS,
   output logic       RegW,
   output logic       MemW,
   output logic       Branch,
   output logic       NextPC,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic [1:0] ResultSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUControl,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc
);

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXECUTER,
      S_EXECUTEI,
      S_ALUWB,
      S_BRANCH
   } state_e;

   localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

   state_e     state_q, state_d;
   logic [3:0] wait_q,  wait_d;
   logic       wait_done;

   // Final cycle of a memory-access state.
   assign wait_done = (wait_q == WAIT_LAST);

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // it unassigned; otherwise synthesis infers a latch.
      state_d = state_q;
      unique case (state_q)
         S_FETCH:    if (wait_done) state_d = S_DECODE;
         S_DECODE: begin
            unique case (Op)
               2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
               2'b01:   state_d = S_MEMADR;
               2'b10:   state_d = S_BRANCH;
               default: state_d = S_FETCH;   // undefined opcode: no side effects
            endcase
         end
         S_MEMADR:   state_d = Funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:    if (wait_done) state_d = S_MEMWB;
         S_MEMWR:    if (wait_done) state_d = S_FETCH;
         S_EXECUTER,
         S_EXECUTEI: state_d = S_ALUWB;
         default:    state_d = S_FETCH;      // MEMWB, ALUWB, BRANCH
      endcase

      // The counter restarts on every state change and otherwise counts up,
      // saturating rather than wrapping.
      if (state_d != state_q) begin
         wait_d = '0;
      end else if (wait_q != 4'hF) begin
         wait_d = wait_q + 4'd1;
      end else begin
         wait_d = wait_q;
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples its pre-edge value regardless of statement order.
      if (reset) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Output decode (Moore, plus Op/Funct-dependent decoders)
   // ---------------------------------------------------------------------------
   state_e dec_state;
   logic   alu_op;
   logic   cmd_ok;

   always_comb begin
      // Reset is synchronous, so the state register can still hold a
      // mid-instruction state while reset is high; decode as FETCH instead.
      dec_state  = reset ? S_FETCH : state_q;

      FlagW      = 2'b00;
      PCS        = 1'b0;
      RegW       = 1'b0;
      MemW       = 1'b0;
      Branch     = 1'b0;
      NextPC     = 1'b0;
      IRWrite    = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUControl = 2'b00;
      ImmSrc     = Op;
      RegSrc     = {(Op == 2'b01), (Op == 2'b10)};
      alu_op     = 1'b0;
      cmd_ok     = 1'b0;

      unique case (dec_state)
         S_FETCH: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = wait_done;
            NextPC    = wait_done;
         end
         S_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         S_MEMADR:   ALUSrcB = 2'b01;
         S_MEMRD:    AdrSrc  = 1'b1;
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegW      = 1'b1;
         end
         S_MEMWR: begin
            AdrSrc = 1'b1;
            MemW   = wait_done;
         end
         S_EXECUTER: alu_op = 1'b1;
         S_EXECUTEI: begin
            ALUSrcB = 2'b01;
            alu_op  = 1'b1;
         end
         S_ALUWB:    RegW = 1'b1;
         S_BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            Branch    = 1'b1;
         end
         default: ;
      endcase

      // ALU decoder: unsupported commands fall back to ADD with no flag writes.
      if (alu_op) begin
         cmd_ok = 1'b1;
         unique case (Funct[4:1])
            4'b0100: ALUControl = 2'b00;
            4'b0010: ALUControl = 2'b01;
            4'b0000: ALUControl = 2'b10;
            4'b1100: ALUControl = 2'b11;
            default: cmd_ok     = 1'b0;
         endcase
         if (cmd_ok) begin
            // Only ADD/SUB produce meaningful C and V.
            FlagW[1] = Funct[0];
            FlagW[0] = Funct[0] & ((ALUControl == 2'b00) | (ALUControl == 2'b01));
         end
      end

      PCS = (RegW & (Rd == 4'hF)) | Branch;

      if (reset) begin
         FlagW   = 2'b00;
         PCS     = 1'b0;
         RegW    = 1'b0;
         MemW    = 1'b0;
         Branch  = 1'b0;
         NextPC  = 1'b0;
         IRWrite = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_controller.sv
// -----------------------------------------------------------------------------
// tb_mc_controller
//   Two controllers (MEM_WAIT=0 and MEM_WAIT=2) run independent instruction
//   streams. For each instruction the stimulus process expands the instruction
//   into its expected per-cycle control vectors and queues them; a monitor per
//   instance pops one vector per cycle and compares it on the falling edge.
// -----------------------------------------------------------------------------
module tb_mc_controller;

   typedef struct packed {
      logic [1:0] flagw;
      logic       pcs;
      logic       regw;
      logic       memw;
      logic       branch;
      logic       nextpc;
      logic       irwrite;
      logic       adrsrc;
      logic [1:0] resultsrc;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] alucontrol;
      logic [1:0] immsrc;
      logic [1:0] regsrc;
   } ctrl_t;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_s [2];
   logic [1:0] op_s    [2];
   logic [5:0] funct_s [2];
   logic [3:0] rd_s    [2];
   ctrl_t      act     [2];

   ctrl_t exp0[$];
   ctrl_t exp1[$];

   int  n_checks = 0;
   int  n_fail   = 0;
   bit  summary_done = 1'b0;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [1:0] flagw, resultsrc, alusrcb, alucontrol, immsrc, regsrc;
      logic       pcs, regw, memw, branch, nextpc, irwrite, adrsrc, alusrca;

      mc_controller #(.MEM_WAIT(g == 0 ? 0 : 2)) dut (
         .clk        (clk),
         .reset      (reset_s[g]),
         .Op         (op_s[g]),
         .Funct      (funct_s[g]),
         .Rd         (rd_s[g]),
         .FlagW      (flagw),
         .PCS        (pcs),
         .RegW       (regw),
         .MemW       (memw),
         .Branch     (branch),
         .NextPC     (nextpc),
         .IRWrite    (irwrite),
         .AdrSrc     (adrsrc),
         .ResultSrc  (resultsrc),
         .ALUSrcA    (alusrca),
         .ALUSrcB    (alusrcb),
         .ALUControl (alucontrol),
         .ImmSrc     (immsrc),
         .RegSrc     (regsrc)
      );

      assign act[g] = {flagw, pcs, regw, memw, branch, nextpc, irwrite, adrsrc,
                       resultsrc, alusrca, alusrcb, alucontrol, immsrc, regsrc};
   end

   // --------------------------------------------------------------------------
   // Reference model: instruction -> list of per-cycle control vectors
   // --------------------------------------------------------------------------
   function automatic ctrl_t base_c(input logic [1:0] op);
      ctrl_t c = '0;
      c.immsrc = op;
      c.regsrc = {(op == 2'b01), (op == 2'b10)};
      return c;
   endfunction

   // PC+4 setup shared by fetch, decode and the reset view.
   function automatic ctrl_t pc4_c(input logic [1:0] op);
      ctrl_t c = base_c(op);
      c.alusrca   = 1'b1;
      c.alusrcb   = 2'b10;
      c.resultsrc = 2'b10;
      return c;
   endfunction

   task automatic build(input logic [1:0] op, input logic [5:0] funct,
                        input logic [3:0] rd, input int w, output ctrl_t s[$]);
      ctrl_t c;
      bit    known, arith;
      logic [1:0] alu;
      s = {};
      // fetch: w+1 cycles, instruction load on the last one
      for (int i = 0; i <= w; i++) begin
         c = pc4_c(op);
         if (i == w) begin
            c.irwrite = 1'b1;
            c.nextpc  = 1'b1;
         end
         s.push_back(c);
      end
      s.push_back(pc4_c(op));                 // decode
      case (op)
         2'b00: begin                         // data processing
            c = base_c(op);
            c.alusrcb = funct[5] ? 2'b01 : 2'b00;
            known = 1'b1; arith = 1'b0; alu = 2'b00;
            case (funct[4:1])
               4'b0100: begin alu = 2'b00; arith = 1'b1; end   // ADD
               4'b0010: begin alu = 2'b01; arith = 1'b1; end   // SUB
               4'b0000: alu = 2'b10;                           // AND
               4'b1100: alu = 2'b11;                           // ORR
               default: known = 1'b0;
            endcase
            c.alucontrol = alu;
            c.flagw      = known ? {funct[0], funct[0] & arith} : 2'b00;
            s.push_back(c);
            c = base_c(op);
            c.regw = 1'b1;
            c.pcs  = (rd == 4'd15);
            s.push_back(c);
         end
         2'b01: begin                         // load / store
            c = base_c(op);
            c.alusrcb = 2'b01;
            s.push_back(c);
            for (int i = 0; i <= w; i++) begin
               c = base_c(op);
               c.adrsrc = 1'b1;
               if (!funct[0] && i == w) c.memw = 1'b1;
               s.push_back(c);
            end
            if (funct[0]) begin
               c = base_c(op);
               c.resultsrc = 2'b01;
               c.regw      = 1'b1;
               c.pcs       = (rd == 4'd15);
               s.push_back(c);
            end
         end
         2'b10: begin                         // branch
            c = base_c(op);
            c.alusrcb   = 2'b01;
            c.resultsrc = 2'b10;
            c.branch    = 1'b1;
            c.pcs       = 1'b1;
            s.push_back(c);
         end
         default: ;                           // undefined: back to fetch
      endcase
   endtask

   // --------------------------------------------------------------------------
   // Stimulus (all tasks start and end just after a rising edge)
   // --------------------------------------------------------------------------
   function automatic int wait_of(input int idx);
      return (idx == 0) ? 0 : 2;
   endfunction

   task automatic push(input int idx, input ctrl_t c);
      if (idx == 0) exp0.push_back(c);
      else          exp1.push_back(c);
   endtask

   task automatic apply_reset(input int idx, input int cycles);
      reset_s[idx] = 1'b1;
      for (int i = 0; i < cycles; i++) push(idx, pc4_c(op_s[idx]));
      repeat (cycles) @(posedge clk);
      #1;
      reset_s[idx] = 1'b0;
   endtask

   // abort_at < 0 runs to completion; otherwise reset is raised for one cycle
   // at that cycle index of the instruction.
   task automatic run_instr(input int idx, input logic [1:0] op,
                            input logic [5:0] funct, input logic [3:0] rd,
                            input int abort_at);
      ctrl_t s[$];
      int    n;
      bit    abort;
      op_s[idx]    = op;
      funct_s[idx] = funct;
      rd_s[idx]    = rd;
      build(op, funct, rd, wait_of(idx), s);
      abort = (abort_at >= 0) && (abort_at < s.size());
      n = abort ? abort_at : s.size();
      for (int i = 0; i < n; i++) push(idx, s[i]);
      repeat (n) @(posedge clk);
      #1;
      if (abort) apply_reset(idx, 1);
   endtask

   task automatic run_random(input int idx, input int count);
      logic [1:0] op;
      logic [5:0] funct;
      logic [3:0] rd;
      logic [3:0] cmds [4];
      int         abort_at;
      cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000; cmds[3] = 4'b1100;
      for (int k = 0; k < count; k++) begin
         op    = 2'($urandom_range(0, 3));
         funct = 6'($urandom);
         if ($urandom_range(0, 1) == 0) funct[4:1] = cmds[$urandom_range(0, 3)];
         rd    = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
         abort_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 9)) : -1;
         run_instr(idx, op, funct, rd, abort_at);
      end
   endtask

   task automatic seq_wait0();
      apply_reset(0, 3);                           // reset held 3 cycles
      run_instr(0, 2'b00, 6'b001001, 4'd1,  -1);   // ADDS R1,R2,R3
      run_instr(0, 2'b01, 6'b011001, 4'd15, -1);   // LDR PC,[R0,#4]
      run_instr(0, 2'b10, 6'b000000, 4'd0,  -1);   // B
      run_instr(0, 2'b11, 6'b111111, 4'd15, -1);   // undefined opcode
      run_instr(0, 2'b00, 6'b000001, 4'd2,  -1);   // ANDS
      run_instr(0, 2'b00, 6'b011111, 4'd3,  -1);   // undefined cmd 1111, S=1
      run_instr(0, 2'b00, 6'b100101, 4'd4,  -1);   // SUBS immediate
      run_instr(0, 2'b00, 6'b011000, 4'd15, -1);   // ORR to PC
      run_instr(0, 2'b01, 6'b011000, 4'd5,  -1);   // STR
      run_random(0, 150);
   endtask

   task automatic seq_wait2();
      apply_reset(1, 2);
      run_instr(1, 2'b01, 6'b011000, 4'd2,  -1);   // STR, 8 cycles
      run_instr(1, 2'b01, 6'b011001, 4'd15, -1);   // LDR PC
      run_instr(1, 2'b01, 6'b011000, 4'd2,  6);    // STR aborted in MEMWR, count 1
      run_instr(1, 2'b00, 6'b001001, 4'd1,  -1);   // ADDS after abort
      run_random(1, 100);
   endtask

   // --------------------------------------------------------------------------
   // Monitor
   // --------------------------------------------------------------------------
   task automatic monitor(input int idx);
      ctrl_t e;
      int    cyc = 0;
      forever begin
         @(negedge clk);
         if ((idx == 0 && exp0.size() > 0) || (idx == 1 && exp1.size() > 0)) begin
            if (idx == 0) e = exp0.pop_front();
            else          e = exp1.pop_front();
            n_checks++;
            if (act[idx] !== e) begin
               n_fail++;
               $display("FAIL ctrl_dut%0d cycle %0d: actual=%05h expected=%05h (op=%b funct=%b rd=%0d reset=%b)",
                        idx, cyc, act[idx], e, op_s[idx], funct_s[idx], rd_s[idx], reset_s[idx]);
            end
            cyc++;
         end
      end
   endtask

   task automatic print_summary();
      if (!summary_done) begin
         summary_done = 1'b1;
         $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         reset_s[i] = 1'b1;
         op_s[i]    = 2'b00;
         funct_s[i] = 6'b000000;
         rd_s[i]    = 4'd0;
      end
      fork
         monitor(0);
         monitor(1);
      join_none
      @(posedge clk);
      #1;
      fork
         seq_wait0();
         seq_wait2();
      join
      @(negedge clk);
      n_checks++;
      if (exp0.size() != 0 || exp1.size() != 0) begin
         n_fail++;
         $display("FAIL drain: actual=%0d/%0d vectors left, required=0/0", exp0.size(), exp1.size());
      end
      print_summary();
      $finish;
   end

   initial begin
      #500000;
      n_checks++;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete within the time limit");
      print_summary();
      $finish;
   end

endmodule
